// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: conditions the raw PS/2 pins, deserialises 11-bit frames
// and assembles three checked bytes into one 24-bit mouse packet.
module ps2_mouse_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic        rd_vld,
    output logic [23:0] rd_data,
    output logic        err_parity,
    output logic        err_frame
);

    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Index 0 carries ps2_clk, index 1 carries ps2_data.
    logic [1:0] pins;
    logic [1:0] sync_meta_reg;
    logic [1:0] sync_reg;

    assign pins = {ps2_data, ps2_clk};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge clk_sys or posedge rst) begin
                if (rst) begin
                    sync_meta_reg[gi] <= 1'b1;
                    sync_reg[gi]      <= 1'b1;
                end else begin
                    sync_meta_reg[gi] <= pins[gi];
                    sync_reg[gi]      <= sync_meta_reg[gi];
                end
            end
        end
    endgenerate

    // The filter window is the stored history plus the incoming sample, so the
    // level can settle in the same edge that completes a run of equal samples.
    logic [FILTER_LEN-2:0] filt_reg;
    logic [FILTER_LEN-1:0] filt_window;
    logic                  level_reg, level_next, level_d_reg;
    logic                  fall_stb;
    logic                  din;

    assign filt_window = {filt_reg, sync_reg[0]};
    assign din         = sync_reg[1];
    assign fall_stb    = level_d_reg & ~level_reg;

    always_comb begin
        level_next = level_reg;
        if (filt_window == '0)
            level_next = 1'b0;
        else if (&filt_window)
            level_next = 1'b1;
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            filt_reg    <= '1;
            level_reg   <= 1'b1;
            level_d_reg <= 1'b1;
        end else begin
            filt_reg    <= filt_window[FILTER_LEN-2:0];
            level_reg   <= level_next;
            level_d_reg <= level_reg;
        end
    end

    state_t           state_reg, state_next;
    logic [2:0]       bit_cnt_reg, bit_cnt_next;
    logic [7:0]       shift_reg, shift_next;
    logic             parity_reg, parity_next;
    logic [1:0]       idx_reg, idx_next;
    logic [7:0]       byte0_reg, byte0_next;
    logic [7:0]       byte1_reg, byte1_next;
    logic [23:0]      rd_data_reg, rd_data_next;
    logic             rd_vld_reg, rd_vld_next;
    logic             err_parity_reg, err_parity_next;
    logic             err_frame_reg, err_frame_next;
    logic [WD_W-1:0]  wd_cnt_reg, wd_cnt_next;
    logic             byte_stb;
    logic             busy;
    logic             timeout;

    assign busy    = (state_reg != IDLE) || (idx_reg != 2'd0);
    assign timeout = (wd_cnt_reg == WD_MAX);

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        parity_next     = parity_reg;
        idx_next        = idx_reg;
        byte0_next      = byte0_reg;
        byte1_next      = byte1_reg;
        rd_data_next    = rd_data_reg;
        rd_vld_next     = 1'b0;
        err_parity_next = 1'b0;
        err_frame_next  = 1'b0;
        wd_cnt_next     = '0;
        byte_stb        = 1'b0;

        if (timeout) begin
            // A coincident clock edge is deliberately discarded here.
            state_next     = IDLE;
            idx_next       = 2'd0;
            err_frame_next = 1'b1;
        end else begin
            if (!fall_stb && busy)
                wd_cnt_next = wd_cnt_reg + 1'b1;

            if (fall_stb) begin
                case (state_reg)
                    IDLE: begin
                        if (!din) begin
                            state_next   = DATA;
                            bit_cnt_next = 3'd0;
                        end
                    end
                    DATA: begin
                        shift_next   = {din, shift_reg[7:1]};
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7)
                            state_next = PARITY;
                    end
                    PARITY: begin
                        parity_next = din;
                        state_next  = STOP;
                    end
                    STOP: begin
                        state_next = IDLE;
                        if (!din) begin
                            err_frame_next = 1'b1;
                            idx_next       = 2'd0;
                        end else if (^{shift_reg, parity_reg} != 1'b1) begin
                            err_parity_next = 1'b1;
                            idx_next        = 2'd0;
                        end else begin
                            byte_stb = 1'b1;
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end

            if (byte_stb) begin
                case (idx_reg)
                    2'd0: begin
                        // Bit 3 of a mouse status byte is always 1; use it to resync.
                        if (shift_reg[3]) begin
                            byte0_next = shift_reg;
                            idx_next   = 2'd1;
                        end else begin
                            err_frame_next = 1'b1;
                        end
                    end
                    2'd1: begin
                        byte1_next = shift_reg;
                        idx_next   = 2'd2;
                    end
                    2'd2: begin
                        rd_data_next = {shift_reg, byte1_reg, byte0_reg};
                        rd_vld_next  = 1'b1;
                        idx_next     = 2'd0;
                    end
                    default: idx_next = 2'd0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= 3'd0;
            shift_reg      <= 8'h00;
            parity_reg     <= 1'b0;
            idx_reg        <= 2'd0;
            byte0_reg      <= 8'h00;
            byte1_reg      <= 8'h00;
            rd_data_reg    <= 24'h000000;
            rd_vld_reg     <= 1'b0;
            err_parity_reg <= 1'b0;
            err_frame_reg  <= 1'b0;
            wd_cnt_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            parity_reg     <= parity_next;
            idx_reg        <= idx_next;
            byte0_reg      <= byte0_next;
            byte1_reg      <= byte1_next;
            rd_data_reg    <= rd_data_next;
            rd_vld_reg     <= rd_vld_next;
            err_parity_reg <= err_parity_next;
            err_frame_reg  <= err_frame_next;
            wd_cnt_reg     <= wd_cnt_next;
        end
    end

    assign rd_vld     = rd_vld_reg;
    assign rd_data    = rd_data_reg;
    assign err_parity = err_parity_reg;
    assign err_frame  = err_frame_reg;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Self-checking bench for ps2_mouse_rx: directed vector table, hand-written
// corner sequences and a randomized frame stream against a packet-level model.
module tb_ps2_mouse_rx;

    localparam int FL    = 8;
    localparam int TO    = 600;
    localparam int HALF  = 20;
    localparam int GAP   = 60;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        rd_vld;
    logic [23:0] rd_data;
    logic        err_parity;
    logic        err_frame;

    ps2_mouse_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd_vld     (rd_vld),
        .rd_data    (rd_data),
        .err_parity (err_parity),
        .err_frame  (err_frame)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Monitor: counts strobes and watches the output-protocol rules.
    int          n_vld = 0, n_perr = 0, n_ferr = 0;
    int          viol_consec = 0, viol_data = 0;
    int          vld_cyc = 0, fall_cyc = 0;
    logic [23:0] prev_data = 24'h0;
    logic        prev_strobe = 1'b0;
    logic [23:0] got_q[$];

    always @(negedge clk_sys) begin
        if (rst) begin
            prev_data   = rd_data;
            prev_strobe = 1'b0;
        end else begin
            if ((rd_vld | err_parity | err_frame) && prev_strobe) viol_consec++;
            if ((rd_data !== prev_data) && !rd_vld) viol_data++;
            if (rd_vld) begin
                n_vld++;
                got_q.push_back(rd_data);
                vld_cyc = cyc;
            end
            if (err_parity) n_perr++;
            if (err_frame) n_ferr++;
            prev_strobe = rd_vld | err_parity | err_frame;
            prev_data   = rd_data;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // flaw: 0 none, 1 inverted parity, 2 stop bit low.
    task automatic send_frame(input logic [7:0] d, input int flaw, input int nbits, input int glitch_bit);
        logic [10:0] bits;
        logic        par;
        par  = ~(^d) ^ (flaw == 1);
        bits = {(flaw == 2) ? 1'b0 : 1'b1, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_cycles(HALF);
            ps2_clk  = 1'b0;
            fall_cyc = cyc;
            wait_cycles(HALF);
            ps2_clk  = 1'b1;
            if (i == glitch_bit) begin
                wait_cycles(5);
                ps2_clk = 1'b0;
                wait_cycles(3);
                ps2_clk = 1'b1;
            end
        end
        ps2_data = 1'b1;
        wait_cycles(GAP);
    endtask

    typedef struct {
        logic [2:0][7:0] fr;        // fr[0] sent first
        int              nfr;
        int              flaw_byte; // -1 for none
        int              flaw;
        int              exp_vld;
        int              exp_perr;
        int              exp_ferr;
        logic [23:0]     exp_data;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int          v0, p0, f0;
        logic [23:0] hold;
        logic [23:0] exp_q[$];
        int          m_idx, m_perr, m_ferr;
        logic [7:0]  m_b0, m_b1;

        tbl[0] = '{fr: {8'hFB, 8'h05, 8'h08}, nfr: 3, flaw_byte: -1, flaw: 0, exp_vld: 1, exp_perr: 0, exp_ferr: 0, exp_data: 24'hFB0508};
        tbl[1] = '{fr: {8'h00, 8'h05, 8'h08}, nfr: 2, flaw_byte: 1, flaw: 1, exp_vld: 0, exp_perr: 1, exp_ferr: 0, exp_data: 24'h0};
        tbl[2] = '{fr: {8'h20, 8'h10, 8'h18}, nfr: 3, flaw_byte: -1, flaw: 0, exp_vld: 1, exp_perr: 0, exp_ferr: 0, exp_data: 24'h201018};
        tbl[3] = '{fr: {8'h00, 8'h00, 8'h00}, nfr: 1, flaw_byte: -1, flaw: 0, exp_vld: 0, exp_perr: 0, exp_ferr: 1, exp_data: 24'h0};
        tbl[4] = '{fr: {8'h02, 8'h01, 8'h09}, nfr: 3, flaw_byte: -1, flaw: 0, exp_vld: 1, exp_perr: 0, exp_ferr: 0, exp_data: 24'h020109};
        tbl[5] = '{fr: {8'h00, 8'h33, 8'h08}, nfr: 2, flaw_byte: 1, flaw: 2, exp_vld: 0, exp_perr: 0, exp_ferr: 1, exp_data: 24'h0};
        tbl[6] = '{fr: {8'h00, 8'hFF, 8'h0F}, nfr: 3, flaw_byte: -1, flaw: 0, exp_vld: 1, exp_perr: 0, exp_ferr: 0, exp_data: 24'h00FF0F};
        tbl[7] = '{fr: {8'hFB, 8'h05, 8'h08}, nfr: 3, flaw_byte: 2, flaw: 1, exp_vld: 0, exp_perr: 1, exp_ferr: 0, exp_data: 24'h0};
        tbl[8] = '{fr: {8'h00, 8'h00, 8'h08}, nfr: 1, flaw_byte: 0, flaw: 1, exp_vld: 0, exp_perr: 1, exp_ferr: 0, exp_data: 24'h0};
        tbl[9] = '{fr: {8'h80, 8'h7E, 8'hC8}, nfr: 3, flaw_byte: -1, flaw: 0, exp_vld: 1, exp_perr: 0, exp_ferr: 0, exp_data: 24'h807EC8};

        // Reset state
        wait_cycles(3);
        check("reset_rd_vld", {31'd0, rd_vld}, 32'd0);
        check("reset_rd_data", {8'd0, rd_data}, 32'd0);
        check("reset_errs", {30'd0, err_parity, err_frame}, 32'd0);
        rst = 1'b0;
        wait_cycles(50);
        check("no_false_edge", n_vld + n_perr + n_ferr, 0);

        hold = 24'h0;
        for (int i = 0; i < 10; i++) begin
            v0 = n_vld; p0 = n_perr; f0 = n_ferr;
            for (int k = 0; k < tbl[i].nfr; k++)
                send_frame(tbl[i].fr[k], (k == tbl[i].flaw_byte) ? tbl[i].flaw : 0, 11, -1);
            if (tbl[i].exp_vld != 0) hold = tbl[i].exp_data;
            $display("vec %0d: vld %0d perr %0d ferr %0d rd_data %h", i,
                     n_vld - v0, n_perr - p0, n_ferr - f0, rd_data);
            check($sformatf("vec%0d_vld", i), n_vld - v0, tbl[i].exp_vld);
            check($sformatf("vec%0d_perr", i), n_perr - p0, tbl[i].exp_perr);
            check($sformatf("vec%0d_ferr", i), n_ferr - f0, tbl[i].exp_ferr);
            check($sformatf("vec%0d_data", i), {8'd0, rd_data}, {8'd0, hold});
            if (tbl[i].exp_vld != 0)
                check($sformatf("vec%0d_latency", i), vld_cyc - fall_cyc, FL + 3);
        end

        // Timeout after the first byte of a packet
        v0 = n_vld; f0 = n_ferr;
        send_frame(8'h08, 0, 11, -1);
        wait_cycles(TO + 10);
        $display("timeout: ferr %0d", n_ferr - f0);
        check("timeout_ferr", n_ferr - f0, 1);
        f0 = n_ferr;
        send_frame(8'h08, 0, 11, -1);
        send_frame(8'hAA, 0, 11, -1);
        send_frame(8'h55, 0, 11, -1);
        $display("after timeout: vld %0d rd_data %h", n_vld - v0, rd_data);
        check("timeout_next_vld", n_vld - v0, 1);
        check("timeout_next_data", {8'd0, rd_data}, 32'h0055AA08);
        check("timeout_next_ferr", n_ferr - f0, 0);

        // Glitch on ps2_clk in the middle of byte1
        v0 = n_vld; p0 = n_perr; f0 = n_ferr;
        send_frame(8'h08, 0, 11, -1);
        send_frame(8'h05, 0, 11, 3);
        send_frame(8'hFB, 0, 11, -1);
        $display("glitch: vld %0d perr %0d ferr %0d rd_data %h", n_vld - v0, n_perr - p0, n_ferr - f0, rd_data);
        check("glitch_vld", n_vld - v0, 1);
        check("glitch_data", {8'd0, rd_data}, 32'h00FB0508);
        check("glitch_errs", (n_perr - p0) + (n_ferr - f0), 0);

        // Reset in the middle of byte1
        send_frame(8'h08, 0, 11, -1);
        send_frame(8'h77, 0, 5, -1);
        rst = 1'b1;
        wait_cycles(3);
        $display("mid-frame reset: rd_vld %b rd_data %h errs %b%b", rd_vld, rd_data, err_parity, err_frame);
        check("rst_rd_data", {8'd0, rd_data}, 32'd0);
        check("rst_strobes", {29'd0, rd_vld, err_parity, err_frame}, 32'd0);
        rst = 1'b0;
        v0 = n_vld; p0 = n_perr; f0 = n_ferr;
        wait_cycles(TO + 20);
        check("rst_quiet", (n_vld - v0) + (n_perr - p0) + (n_ferr - f0), 0);
        send_frame(8'h28, 0, 11, -1);
        send_frame(8'h7F, 0, 11, -1);
        send_frame(8'h80, 0, 11, -1);
        $display("after reset: vld %0d rd_data %h", n_vld - v0, rd_data);
        check("rst_next_vld", n_vld - v0, 1);
        check("rst_next_data", {8'd0, rd_data}, 32'h00807F28);

        // Random frame stream against a packet-level model
        got_q.delete();
        v0 = n_vld; p0 = n_perr; f0 = n_ferr;
        m_idx = 0; m_perr = 0; m_ferr = 0; m_b0 = 8'h0; m_b1 = 8'h0;
        for (int t = 0; t < 30; t++) begin
            logic [7:0] b;
            int         r, fl;
            b  = 8'($urandom);
            if ($urandom_range(0, 3) != 0) b[3] = 1'b1;
            r  = $urandom_range(0, 9);
            fl = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            send_frame(b, fl, 11, -1);
            $display("rand %0d: byte %h flaw %0d", t, b, fl);
            if (fl == 2) begin
                m_ferr++; m_idx = 0;
            end else if (fl == 1) begin
                m_perr++; m_idx = 0;
            end else if (m_idx == 0) begin
                if (b[3]) begin m_b0 = b; m_idx = 1; end
                else m_ferr++;
            end else if (m_idx == 1) begin
                m_b1 = b; m_idx = 2;
            end else begin
                exp_q.push_back({b, m_b1, m_b0});
                m_idx = 0;
            end
        end
        wait_cycles(TO + 50);
        if (m_idx != 0) m_ferr++;
        check("rand_vld_count", n_vld - v0, exp_q.size());
        check("rand_perr", n_perr - p0, m_perr);
        check("rand_ferr", n_ferr - f0, m_ferr);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < got_q.size()) begin
                $display("rand packet %0d: got %h exp %h", k, got_q[k], exp_q[k]);
                check($sformatf("rand_pkt%0d", k), {8'd0, got_q[k]}, {8'd0, exp_q[k]});
            end
        end

        check("no_consecutive_strobes", viol_consec, 0);
        check("rd_data_only_with_vld", viol_data, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
